// File: rtl/fpu_rcp_nr_iter_pkg.sv
// Shared FPU definitions for the FP64 reciprocal Newton-Raphson refinement unit:
// field widths, exponent constants, fixed-point formats and the control states.
package fpu_rcp_nr_iter_pkg;

  // FP64 field layout
  localparam int FP_WIDTH   = 64;
  localparam int EXP_WIDTH  = 11;
  localparam int FRAC_WIDTH = 52;
  localparam int EXP_LSB    = 52;
  localparam int SIGN_BIT   = 63;

  // Exponent constants used by the reciprocal exponent math and special cases
  localparam logic [EXP_WIDTH-1:0] EXP_7FD = 11'h7FD;
  localparam logic [EXP_WIDTH-1:0] EXP_7FE = 11'h7FE;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = 11'h7FF;

  // Fraction bit that marks a NaN as quiet
  localparam int QNAN_BIT = 51;

  // Fixed-point datapath: Q2.55 operands, 1.0 lives at bit 55
  localparam int FIX_WIDTH  = 57;
  localparam int FIX_FRAC   = 55;
  localparam int PROD_WIDTH = 2 * FIX_WIDTH;
  localparam logic [FIX_WIDTH-1:0] FIX_ONE = 57'd1 << FIX_FRAC;
  localparam logic [FIX_WIDTH-1:0] FIX_TWO = 57'd1 << (FIX_FRAC + 1);

  typedef enum logic [2:0] {
    IDLE,
    MUL_E,
    MUL_X,
    NORM,
    DONE
  } rcpState_e;

  // Zero/denormal, infinity and NaN operands never enter the multiply loop
  function automatic logic isSpecial(input logic [FP_WIDTH-1:0] v);
    return (v[62:EXP_LSB] == '0) || (v[62:EXP_LSB] == EXP_MAX);
  endfunction

  // Reciprocal of a special operand: 1/0 = inf, 1/inf = 0, NaN is quieted
  function automatic logic [FP_WIDTH-1:0] specialResult(input logic [FP_WIDTH-1:0] v);
    logic [FP_WIDTH-1:0] res;
    if (v[62:EXP_LSB] == '0) begin
      res = {v[SIGN_BIT], EXP_MAX, {FRAC_WIDTH{1'b0}}};
    end else if (v[FRAC_WIDTH-1:0] == '0) begin
      res = {v[SIGN_BIT], {EXP_WIDTH{1'b0}}, {FRAC_WIDTH{1'b0}}};
    end else begin
      res = v;
      res[QNAN_BIT] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fpu_mul57_u.sv
// 57x57 unsigned multiplier shared by both Newton-Raphson passes.
// Purely combinational; the caller captures the window it needs into registers.
module fpu_mul57_u
  import fpu_rcp_nr_iter_pkg::*;
(
  input  logic [FIX_WIDTH-1:0]  opA,
  input  logic [FIX_WIDTH-1:0]  opB,
  output logic [PROD_WIDTH-1:0] prod
);

  assign prod = opA * opB;

endmodule

// File: rtl/fpu_rcp_nr_iter.sv
// FP64 reciprocal refinement: takes divisor and ~20-bit seed, runs NR_ITER
// Newton-Raphson iterations (E = D*X, F = 2-E, X = X*F) on one shared multiplier,
// then normalises and rounds the Q2.55 estimate into an FP64 result.
module fpu_rcp_nr_iter
  import fpu_rcp_nr_iter_pkg::*;
#(
  parameter int NR_ITER = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                exStart,
  input  logic [FP_WIDTH-1:0] valRm,
  input  logic [FP_WIDTH-1:0] valApx,
  output logic [FP_WIDTH-1:0] valRn,
  output logic                exBusy,
  output logic                exDone
);

  localparam int CNT_WIDTH = $clog2(NR_ITER + 1);

  rcpState_e stateReg, stateNext;

  logic [CNT_WIDTH-1:0] iterCntReg;
  logic                 signReg;
  logic [EXP_WIDTH-1:0] expReg;
  logic [FIX_WIDTH-1:0] dReg;
  logic [FIX_WIDTH-1:0] xReg;
  logic [FIX_WIDTH-1:0] fReg;

  logic [FIX_WIDTH-1:0]  mulA;
  logic [FIX_WIDTH-1:0]  mulB;
  logic [PROD_WIDTH-1:0] prod;
  logic [FIX_WIDTH-1:0]  prodFix;
  logic                  lastIter;

  logic [11:0]          seedSh;
  logic [FIX_WIDTH-1:0] seedX;

  logic [11:0]           normExp;
  logic [EXP_WIDTH-1:0]  normExpRnd;
  logic [FRAC_WIDTH:0]   mantRnd;
  logic [FRAC_WIDTH-1:0] normMant;
  logic [FP_WIDTH-1:0]   normResult;
  logic                  unusedBits;

  // Seed alignment: the seed exponent only tells us whether X is exactly 1.0
  // (power-of-two divisor) or lies in (0.5,1); the seed sign is irrelevant.
  assign seedSh = 12'h7FE - {1'b0, valRm[62:EXP_LSB]} - {1'b0, valApx[62:EXP_LSB]};
  // {01,frac,000} >> 1 written directly as {001,frac,00}
  assign seedX  = (seedSh == 12'd0) ? FIX_ONE : {3'b001, valApx[FRAC_WIDTH-1:0], 2'b00};

  // Operand mux: D*X while forming the error term, X*F while refining
  assign mulA = (stateReg == MUL_E) ? dReg : xReg;
  assign mulB = (stateReg == MUL_E) ? xReg : fReg;

  fpu_mul57_u uMul (
    .opA  (mulA),
    .opB  (mulB),
    .prod (prod)
  );

  // Q4.110 product truncated back to Q2.55, keeping both integer bits
  assign prodFix  = prod[FIX_FRAC + FIX_WIDTH - 1:FIX_FRAC];
  assign lastIter = (iterCntReg == CNT_WIDTH'(NR_ITER - 1));

  // Product bits outside the Q2.55 window and the seed sign are not needed
  assign unusedBits = ^{prod[PROD_WIDTH-1:FIX_FRAC + FIX_WIDTH], prod[FIX_FRAC-1:0],
                        valApx[SIGN_BIT]};

  // State register
  always_ff @(posedge clock) begin
    if (!reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  // Next-state logic: specials go straight to DONE, others loop MUL_E/MUL_X
  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE:    if (exStart) stateNext = isSpecial(valRm) ? DONE : MUL_E;
      MUL_E:   stateNext = MUL_X;
      MUL_X:   stateNext = lastIter ? NORM : MUL_E;
      NORM:    stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so busy covers DONE
  always_ff @(posedge clock) begin
    if (!reset) begin
      exBusy <= 1'b0;
      exDone <= 1'b0;
    end else begin
      exBusy <= (stateNext != IDLE);
      exDone <= (stateNext == DONE);
    end
  end

  // Normalise the refined estimate: X >= 1.0 only for power-of-two divisors,
  // otherwise X in (0.5,1) so bit 54 is the hidden bit and bit 1 rounds.
  always_comb begin
    normExp    = 12'd0;
    mantRnd    = '0;
    normExpRnd = '0;
    normMant   = '0;
    normResult = '0;
    if (xReg[FIX_FRAC]) begin
      normExp = {1'b0, EXP_7FE} - {1'b0, expReg};
      mantRnd = '0;
    end else begin
      normExp = {1'b0, EXP_7FD} - {1'b0, expReg};
      mantRnd = {1'b0, xReg[53:2]} + {{FRAC_WIDTH{1'b0}}, xReg[1]};
    end
    normExpRnd = normExp[EXP_WIDTH-1:0] + {{(EXP_WIDTH-1){1'b0}}, mantRnd[FRAC_WIDTH]};
    normMant   = mantRnd[FRAC_WIDTH] ? '0 : mantRnd[FRAC_WIDTH-1:0];
    // Non-positive pre-round exponent would be denormal: flush to signed zero
    if (normExp[11] || (normExp == 12'd0)) begin
      normResult = {signReg, {(FP_WIDTH-1){1'b0}}};
    end else begin
      normResult = {signReg, normExpRnd, normMant};
    end
  end

  // Datapath registers: operand capture, iteration updates and result
  always_ff @(posedge clock) begin
    if (!reset) begin
      iterCntReg <= '0;
      signReg    <= 1'b0;
      expReg     <= '0;
      dReg       <= '0;
      xReg       <= '0;
      fReg       <= '0;
      valRn      <= '0;
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (exStart) begin
            signReg    <= valRm[SIGN_BIT];
            expReg     <= valRm[62:EXP_LSB];
            dReg       <= {2'b01, valRm[FRAC_WIDTH-1:0], 3'b000};
            xReg       <= seedX;
            iterCntReg <= '0;
            if (isSpecial(valRm)) valRn <= specialResult(valRm);
          end
        end
        MUL_E: fReg <= FIX_TWO - prodFix;
        MUL_X: begin
          xReg       <= prodFix;
          iterCntReg <= iterCntReg + 1'b1;
        end
        NORM:    valRn <= normResult;
        DONE:    ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_rcp_nr_iter.sv
// Scoreboard bench for fpu_rcp_nr_iter: stimulus pushes expected results
// (from real-number division) into a queue, a monitor pops on every exDone.
module tb_fpu_rcp_nr_iter;

  localparam int NR_ITER  = 2;
  localparam int LAT_NORM = 2 * NR_ITER + 2;
  localparam int LAT_SPEC = 1;
  localparam int N_RAND   = 3000;

  logic        clock = 1'b0;
  logic        reset;
  logic        exStart;
  logic [63:0] valRm;
  logic [63:0] valApx;
  logic [63:0] valRn;
  logic        exBusy;
  logic        exDone;

  always #5 clock = ~clock;

  fpu_rcp_nr_iter #(.NR_ITER(NR_ITER)) dut (
    .clock   (clock),
    .reset   (reset),
    .exStart (exStart),
    .valRm   (valRm),
    .valApx  (valApx),
    .valRn   (valRn),
    .exBusy  (exBusy),
    .exDone  (exDone)
  );

  typedef struct {
    logic [63:0] rm;
    logic [63:0] want;
    int          tol;
    int          lat;
    int          startCyc;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  sbEntry_t curEnt;
  int       curLat;
  int       checks   = 0;
  int       errors   = 0;
  int       cycleCnt = 0;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Reference: 1/d by real division, with the block's special and flush rules
  function automatic void refModel(input logic [63:0] rm, output logic [63:0] want,
                                   output int tol, output int lat);
    logic [10:0] e;
    logic [51:0] f;
    real         r;
    logic [63:0] rb;
    e   = rm[62:52];
    f   = rm[51:0];
    tol = 0;
    lat = LAT_SPEC;
    if (e == 11'd0) begin
      want = {rm[63], 11'h7FF, 52'd0};
    end else if (e == 11'h7FF) begin
      want = (f == 52'd0) ? {rm[63], 63'd0} : (rm | (64'd1 << 51));
    end else begin
      lat  = LAT_NORM;
      r    = 1.0 / $bitstoreal({1'b0, rm[62:0]});
      rb   = $realtobits(r);
      if (rb[62:52] == 11'd0) want = {rm[63], 63'd0};
      else                    want = {rm[63], rb[62:0]};
      tol  = (f == 52'd0) ? 0 : 1;
    end
  endfunction

  // Coarse seed as the lookup would give it: 1/mantissa truncated to 20 bits
  function automatic logic [63:0] lookupSeed(input logic [63:0] rm);
    real         m;
    logic [63:0] rr;
    logic [10:0] fld;
    m        = $bitstoreal({12'h3FF, rm[51:0]});
    rr       = $realtobits(1.0 / m);
    rr[31:0] = 32'd0;
    fld      = rr[62:52] + 11'h3FF - rm[62:52];
    return {1'($urandom_range(0, 1)), fld, rr[51:0]};
  endfunction

  function automatic logic [63:0] randOperand();
    logic [63:0] v;
    int          sel;
    v   = {$urandom, $urandom};
    sel = int'($urandom_range(0, 99));
    if (sel < 4)       v[62:52] = 11'd0;
    else if (sel < 8)  v[62:52] = 11'h7FF;
    else if (sel < 10) begin v[62:52] = 11'h7FF; v[51:0] = 52'd0; end
    else if (sel < 18) v[51:0] = 52'd0;
    else if (sel < 22) v[62:52] = 11'h7FC + 11'($urandom_range(0, 2));
    else if (sel < 25) v[62:52] = 11'd1 + 11'($urandom_range(0, 2));
    return v;
  endfunction

  function automatic bit withinUlp(input logic [63:0] got, input logic [63:0] want, input int tol);
    longint unsigned a, b, d;
    if (got[63] != want[63]) return 1'b0;
    a = {1'b0, got[62:0]};
    b = {1'b0, want[62:0]};
    d = (a >= b) ? (a - b) : (b - a);
    return d <= longint'(tol);
  endfunction

  // Start an operation at the next free slot; call at a falling edge
  task automatic issue(input logic [63:0] rm, input logic [63:0] apx, input logic [63:0] want,
                       input int tol, input int lat, input bit track);
    int waitCyc;
    waitCyc = 0;
    while (exBusy && waitCyc < 100) begin
      @(negedge clock);
      waitCyc++;
    end
    checks++;
    if (exBusy) begin
      errors++;
      $display("FAIL issue_wait exBusy=%b required=0 rm=%h", exBusy, rm);
    end
    valRm   = rm;
    valApx  = apx;
    exStart = 1'b1;
    if (track) sbQ.push_back('{rm, want, tol, lat, cycleCnt + 1});
    @(negedge clock);
    exStart = 1'b0;
    checks++;
    if (exBusy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start exBusy=%b required=1 rm=%h", exBusy, rm);
    end
  endtask

  // Monitor: every exDone must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (reset && exDone) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done valRn=%h required=no_done", valRn);
      end else begin
        curEnt = sbQ.pop_front();
        curLat = cycleCnt - curEnt.startCyc + 1;
        checks++;
        if (!withinUlp(valRn, curEnt.want, curEnt.tol)) begin
          errors++;
          $display("FAIL result rm=%h got=%h required=%h tol=%0d", curEnt.rm, valRn,
                   curEnt.want, curEnt.tol);
        end
        checks++;
        if (curLat != curEnt.lat) begin
          errors++;
          $display("FAIL latency rm=%h got=%0d required=%0d", curEnt.rm, curLat, curEnt.lat);
        end
        $display("txn rm=%h rn=%h want=%h lat=%0d", curEnt.rm, valRn, curEnt.want, curLat);
      end
    end
  end

  task automatic drain();
    int w;
    w = 0;
    while (sbQ.size() != 0 && w < 200) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbQ.size());
      sbQ.delete();
    end
  endtask

  initial begin
    logic [63:0] rm, apx, want;
    int          tol, lat;

    reset   = 1'b0;
    exStart = 1'b0;
    valRm   = '0;
    valApx  = '0;
    repeat (3) @(negedge clock);
    checks += 3;
    if (valRn !== 64'd0) begin errors++; $display("FAIL reset_valRn got=%h required=0", valRn); end
    if (exBusy !== 1'b0) begin errors++; $display("FAIL reset_exBusy got=%b required=0", exBusy); end
    if (exDone !== 1'b0) begin errors++; $display("FAIL reset_exDone got=%b required=0", exDone); end
    reset = 1'b1;
    @(negedge clock);

    // Directed cases with hand-derived results
    issue(64'h4000000000000000, 64'h3FE0000000000000, 64'h3FE0000000000000, 0, LAT_NORM, 1'b1);
    issue(64'h4008000000000000, lookupSeed(64'h4008000000000000), 64'h3FD5555555555555, 1,
          LAT_NORM, 1'b1);
    issue(64'h0000000000000000, 64'h0, 64'h7FF0000000000000, 0, LAT_SPEC, 1'b1);
    issue(64'hFFF0000000000000, 64'h0, 64'h8000000000000000, 0, LAT_SPEC, 1'b1);
    issue(64'h7FF0000000000001, 64'h0, 64'h7FF8000000000001, 0, LAT_SPEC, 1'b1);
    issue(64'h7FE0000000000000, lookupSeed(64'h7FE0000000000000), 64'h0, 0, LAT_NORM, 1'b1);
    drain();

    // Starts during a busy op (including the exDone cycle) are ignored;
    // the start right after exDone is taken.
    issue(64'h4008000000000000, lookupSeed(64'h4008000000000000), 64'h3FD5555555555555, 1,
          LAT_NORM, 1'b1);
    for (int k = 2; k <= LAT_NORM; k++) begin
      @(negedge clock);
      valRm   = 64'h3FF8000000000000 + 64'(k);
      valApx  = 64'h3FE0000000000000;
      exStart = 1'b1;
    end
    @(negedge clock);
    issue(64'hC010000000000000, lookupSeed(64'hC010000000000000), 64'hBFD0000000000000, 0,
          LAT_NORM, 1'b1);
    drain();

    // Reset in the middle of an operation discards it
    issue(64'h4014000000000000, lookupSeed(64'h4014000000000000), 64'h0, 0, LAT_NORM, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks += 3;
    if (exBusy !== 1'b0) begin errors++; $display("FAIL midreset_exBusy got=%b required=0", exBusy); end
    if (valRn !== 64'd0) begin errors++; $display("FAIL midreset_valRn got=%h required=0", valRn); end
    if (exDone !== 1'b0) begin errors++; $display("FAIL midreset_exDone got=%b required=0", exDone); end
    reset = 1'b1;
    repeat (10) @(negedge clock);

    // Random sweep against the real-division reference
    for (int i = 0; i < N_RAND; i++) begin
      rm  = randOperand();
      apx = lookupSeed(rm);
      refModel(rm, want, tol, lat);
      issue(rm, apx, want, tol, lat, 1'b1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d required=finish", cycleCnt);
    $fatal(1, "watchdog expired");
  end

endmodule
